// File: rtl/seg7_scan_ctrl_if.sv
// Signal bundle between a display client and the 3-digit 7-segment scan controller.
// The client (master) supplies the value, load strobe and blanking mode; the controller drives the display.
interface seg7_scan_ctrl_if;
    logic [11:0] VALUE;
    logic        LOAD;
    logic        LZB;
    logic        PENDING;
    logic        FRAME_TICK;
    logic [2:0]  DIG;
    logic [6:0]  SEG;

    modport master (
        output VALUE, LOAD, LZB,
        input  PENDING, FRAME_TICK, DIG, SEG
    );

    modport slave (
        input  VALUE, LOAD, LZB,
        output PENDING, FRAME_TICK, DIG, SEG
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 3-digit 7-segment scan controller with per-slot blanking gap,
// leading-zero blanking and a double-buffered value committed on frame boundaries.
module seg7_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1000
) (
    input  logic              CLK,
    input  logic              RST,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

    typedef enum logic {
        SLOT_BLANK,
        SLOT_ON
    } slot_t;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [11:0]   r_shadow;
    logic [11:0]   r_disp;
    logic          r_pending;
    logic          r_frame_tick;
    logic [2:0]    r_dig;
    logic [6:0]    r_seg;

    logic          w_wrap;
    logic          w_boundary;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_idx_nxt;
    logic [11:0]   w_shadow_nxt;
    logic [11:0]   w_disp_nxt;
    logic          w_pending_nxt;
    slot_t         w_slot_nxt;
    logic [3:0]    w_nib;
    logic          w_lz;
    logic [2:0]    w_dig_nxt;
    logic [6:0]    w_seg_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign w_wrap     = (r_cnt == LAST);
    assign w_boundary = w_wrap && (r_idx == 2'd2);
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt  = !w_wrap ? r_idx : ((r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1);

    // A load landing on the boundary bypasses the shadow so it is shown this frame.
    always_comb begin
        w_disp_nxt    = r_disp;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        if (w_boundary && bus.LOAD) begin
            w_disp_nxt    = bus.VALUE;
            w_pending_nxt = 1'b0;
        end else if (w_boundary && r_pending) begin
            w_disp_nxt    = r_shadow;
            w_pending_nxt = 1'b0;
        end else if (bus.LOAD) begin
            w_shadow_nxt  = bus.VALUE;
            w_pending_nxt = 1'b1;
        end
    end

    generate
        if (BLANK == 0) begin : g_noblank
            assign w_slot_nxt = SLOT_ON;
        end else begin : g_blank
            assign w_slot_nxt = (w_cnt_nxt < BLANK_C) ? SLOT_BLANK : SLOT_ON;
        end
    endgenerate

    // Outputs are computed from next-state values so the registers track cnt/idx with no lag.
    always_comb begin
        w_nib     = w_disp_nxt[3:0];
        w_lz      = 1'b0;
        w_dig_nxt = '0;
        w_seg_nxt = '0;
        case (w_idx_nxt)
            2'd1: begin
                w_nib = w_disp_nxt[7:4];
                w_lz  = bus.LZB && (w_disp_nxt[11:4] == '0);
            end
            2'd2: begin
                w_nib = w_disp_nxt[11:8];
                w_lz  = bus.LZB && (w_disp_nxt[11:8] == '0);
            end
            default: ;
        endcase
        if (w_slot_nxt == SLOT_ON) begin
            w_dig_nxt = 3'b001 << w_idx_nxt;
            w_seg_nxt = w_lz ? '0 : seg_decode(w_nib);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_disp       <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_dig        <= '0;
            r_seg        <= '0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_disp       <= w_disp_nxt;
            r_pending    <= w_pending_nxt;
            r_frame_tick <= w_boundary;
            r_dig        <= w_dig_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign bus.PENDING    = r_pending;
    assign bus.FRAME_TICK = r_frame_tick;
    assign bus.DIG        = r_dig;
    assign bus.SEG        = r_seg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: two instances (DIV=8/BLANK=2 and DIV=2/BLANK=0)
// share stimulus; a cycle-count reference model queues expected outputs, monitors compare.
module tb_seg7_scan_ctrl;

    localparam int DIV0 = 8;
    localparam int BLK0 = 2;
    localparam int DIV1 = 2;
    localparam int BLK1 = 0;
    localparam int FRAME0 = 3 * DIV0;

    logic CLK;
    logic RST;

    seg7_scan_ctrl_if ifc ();
    seg7_scan_ctrl_if ifc2 ();

    assign ifc2.VALUE = ifc.VALUE;
    assign ifc2.LOAD  = ifc.LOAD;
    assign ifc2.LZB   = ifc.LZB;

    seg7_scan_ctrl #(.DIV(DIV0), .BLANK(BLK0)) u_dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    seg7_scan_ctrl #(.DIV(DIV1), .BLANK(BLK1)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc2.slave)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference state per instance: cycles since reset, displayed/shadow value, pending flag.
    int          m_n      [2];
    logic [11:0] m_disp   [2];
    logic [11:0] m_shadow [2];
    logic        m_pend   [2];
    logic [11:0] q0 [$];
    logic [11:0] q1 [$];

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        return tab[d];
    endfunction

    function automatic logic [11:0] model_out(input int n, input int div, input int blank,
                                              input logic [11:0] disp, input logic lzb,
                                              input logic pend);
        int         pos;
        int         d;
        logic       tick;
        logic [2:0] dig;
        logic [6:0] seg;
        logic [3:0] nib;
        pos  = n % div;
        d    = (n / div) % 3;
        tick = (n > 0) && (n % (3 * div) == 0);
        dig  = 3'b000;
        seg  = 7'h00;
        if (pos >= blank) begin
            dig = 3'(1 << d);
            nib = 4'(disp >> (4 * d));
            seg = seg_ref(nib);
            if (lzb && d == 2 && disp[11:8] == 4'h0) seg = 7'h00;
            if (lzb && d == 1 && disp[11:4] == 8'h00) seg = 7'h00;
        end
        return {pend, tick, dig, seg};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s at %0t: got %03h expected %03h", name, $time, act, exp);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: advance per edge, apply load/commit rules, queue expected outputs.
    initial forever begin
        @(posedge CLK or posedge RST);
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                m_n[i]      = 0;
                m_disp[i]   = 12'h000;
                m_shadow[i] = 12'h000;
                m_pend[i]   = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                int   div;
                logic bnd;
                div = (i == 0) ? DIV0 : DIV1;
                m_n[i]++;
                bnd = (m_n[i] % (3 * div) == 0);
                if (bnd && ifc.LOAD) begin
                    m_disp[i] = ifc.VALUE;
                    m_pend[i] = 1'b0;
                end else if (bnd && m_pend[i]) begin
                    m_disp[i] = m_shadow[i];
                    m_pend[i] = 1'b0;
                end else if (ifc.LOAD) begin
                    m_shadow[i] = ifc.VALUE;
                    m_pend[i]   = 1'b1;
                end
            end
            q0.push_back(model_out(m_n[0], DIV0, BLK0, m_disp[0], ifc.LZB, m_pend[0]));
            q1.push_back(model_out(m_n[1], DIV1, BLK1, m_disp[1], ifc.LZB, m_pend[1]));
        end
    end

    // Monitor: sample on the falling edge, away from the active edge.
    initial forever begin
        logic [11:0] a0;
        logic [11:0] a1;
        @(negedge CLK);
        a0 = {ifc.PENDING, ifc.FRAME_TICK, ifc.DIG, ifc.SEG};
        a1 = {ifc2.PENDING, ifc2.FRAME_TICK, ifc2.DIG, ifc2.SEG};
        if (RST || q0.size() == 0) check("reset_div8", a0, 12'h000);
        else                       check("scan_div8", a0, q0.pop_front());
        if (RST || q1.size() == 0) check("reset_div2", a1, 12'h000);
        else                       check("scan_div2", a1, q1.pop_front());
        check("onehot_div8", 12'($onehot0(ifc.DIG)), 12'h001);
        check("onehot_div2", 12'($onehot0(ifc2.DIG)), 12'h001);
    end

    task automatic cycles(input int k);
        repeat (k) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_mod(input int m);
        for (int i = 0; i < 200; i++) begin
            if (m_n[0] % FRAME0 == m) return;
            cycles(1);
        end
        checks_total++;
        $display("FAIL wait_mod: frame position %0d not reached, got %0d", m, m_n[0] % FRAME0);
    endtask

    task automatic pulse_load(input logic [11:0] v);
        ifc.VALUE = v;
        ifc.LOAD  = 1'b1;
        cycles(1);
        ifc.LOAD  = 1'b0;
    endtask

    task automatic load_at(input int m, input logic [11:0] v);
        wait_mod(m);
        pulse_load(v);
    endtask

    initial begin
        RST       = 1'b0;
        ifc.VALUE = 12'h000;
        ifc.LOAD  = 1'b0;
        ifc.LZB   = 1'b0;
        #2 RST = 1'b1;
        cycles(3);
        RST = 1'b0;
        cycles(30);

        load_at(10, 12'h123);
        cycles(50);

        load_at(23, 12'h456);
        load_at(5, 12'h111);
        load_at(9, 12'h222);
        cycles(50);

        ifc.LZB = 1'b1;
        load_at(5, 12'h007);
        cycles(30);
        load_at(5, 12'h000);
        cycles(30);
        load_at(5, 12'h070);
        cycles(30);

        ifc.LZB = 1'b0;
        load_at(5, 12'h0A5);
        cycles(40);

        // Asynchronous reset in the middle of an ON window.
        wait_mod(13);
        #2 RST = 1'b1;
        #1 check("async_reset_div8", {ifc.PENDING, ifc.FRAME_TICK, ifc.DIG, ifc.SEG}, 12'h000);
        check("async_reset_div2", {ifc2.PENDING, ifc2.FRAME_TICK, ifc2.DIG, ifc2.SEG}, 12'h000);
        cycles(2);
        RST = 1'b0;
        cycles(30);

        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 49) == 0) ifc.LZB = ~ifc.LZB;
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    ifc.VALUE = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                 4'($urandom_range(0, 9))};
                else if ($urandom_range(0, 2) == 0)
                    ifc.VALUE = {8'h00, 4'($urandom_range(0, 15))};
                else
                    ifc.VALUE = 12'($urandom);
                ifc.LOAD = 1'b1;
            end else begin
                ifc.LOAD = 1'b0;
            end
            cycles(1);
        end
        ifc.LOAD = 1'b0;
        cycles(30);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
